// File: rtl/sram_fifo_pkg.sv
// Shared sizing and types for the SRAM-backed FIFO controller (32x512 1rw1r macro).
package sram_fifo_pkg;
  localparam int ADDR_WIDTH = 9;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WMASKS = DATA_WIDTH / 8;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0]   ptr_t;
  typedef logic [ADDR_WIDTH+1:0] level_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
endpackage

// File: rtl/sram_fifo_skid.sv
// Two-entry in-order output buffer fed by SRAM read returns; head visible same cycle it is written.
// Pop and fill may coincide; the caller guarantees a fill never lands on a full buffer.
module sram_fifo_skid
  import sram_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push_vld,
  input  data_t      i_push_dat,
  input  logic       i_pop,
  output logic       o_vld,
  output data_t      o_dat,
  output logic [1:0] o_cnt
);
  logic [1:0] r_cnt;
  data_t      r_head;
  data_t      r_tail;
  logic       w_pop;

  assign w_pop = i_pop & (r_cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 2'd0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_cnt <= r_cnt + {1'b0, i_push_vld} - {1'b0, w_pop};
      case ({i_push_vld, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= i_push_dat;
          else               r_tail <= i_push_dat;
        end
        2'b01: r_head <= r_tail;
        2'b11: begin
          // With one entry the new word becomes head; with two it slides behind the old tail
          if (r_cnt == 2'd1) begin
            r_head <= i_push_dat;
          end else begin
            r_head <= r_tail;
            r_tail <= i_push_dat;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_vld = (r_cnt != 2'd0);
  assign o_dat = r_head;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/sram_fifo_ctrl.sv
// Single-clock FIFO around a 1rw1r SRAM; push->out_valid 2 cycles after the write edge, 1 word/cycle streaming.
// in_ready drops when the SRAM holds DEPTH words; optional high-watermark under SRAM_FIFO_WMARK_EN.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [ADDR_WIDTH+1:0]   level,
  output logic                    sram_csb0,
  output logic                    sram_web0,
  output logic [NUM_WMASKS-1:0]   sram_wmask0,
  output logic [ADDR_WIDTH-1:0]   sram_addr0,
  output logic [DATA_WIDTH-1:0]   sram_din0,
  output logic                    sram_csb1,
  output logic [ADDR_WIDTH-1:0]   sram_addr1,
`ifdef SRAM_FIFO_WMARK_EN
  input  logic                    wmark_clr,
  output logic [ADDR_WIDTH+1:0]   wmark,
`endif
  input  logic [DATA_WIDTH-1:0]   sram_dout1
);
  ptr_t       r_wr_ptr;
  ptr_t       r_rd_ptr;
  logic       r_inflight;
  logic       r_in_rdy;
  ptr_t       w_sram_cnt;
  ptr_t       w_wr_nxt;
  ptr_t       w_rd_nxt;
  ptr_t       w_cnt_nxt;
  logic       w_push;
  logic       w_pop;
  logic       w_rd_issue;
  logic [1:0] w_buf_cnt;
  logic [1:0] w_occ;

  assign w_sram_cnt = r_wr_ptr - r_rd_ptr;
  assign w_push     = in_valid & r_in_rdy;
  assign w_pop      = out_valid & out_ready;
  assign w_occ      = w_buf_cnt + {1'b0, r_inflight};
  // Reads only chase the registered write pointer, so a word is never read on its write edge
  assign w_rd_issue = (w_sram_cnt != '0) && ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));
  assign w_wr_nxt   = r_wr_ptr + ptr_t'(w_push);
  assign w_rd_nxt   = r_rd_ptr + ptr_t'(w_rd_issue);
  assign w_cnt_nxt  = w_wr_nxt - w_rd_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
      r_in_rdy   <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_nxt;
      r_rd_ptr   <= w_rd_nxt;
      r_inflight <= w_rd_issue;
      // Count never exceeds DEPTH, so its top bit alone flags full
      r_in_rdy   <= ~w_cnt_nxt[ADDR_WIDTH];
    end
  end

  assign in_ready    = r_in_rdy;
  assign level       = level_t'(w_sram_cnt) + level_t'(r_inflight) + level_t'(w_buf_cnt);
  assign sram_csb0   = ~w_push;
  assign sram_web0   = ~w_push;
  assign sram_wmask0 = {NUM_WMASKS{w_push}};
  assign sram_addr0  = r_wr_ptr[ADDR_WIDTH-1:0];
  assign sram_din0   = in_data;
  assign sram_csb1   = ~w_rd_issue;
  assign sram_addr1  = r_rd_ptr[ADDR_WIDTH-1:0];

  sram_fifo_skid u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_vld (r_inflight),
    .i_push_dat (sram_dout1),
    .i_pop      (w_pop),
    .o_vld      (out_valid),
    .o_dat      (out_data),
    .o_cnt      (w_buf_cnt)
  );

`ifdef SRAM_FIFO_WMARK_EN
  level_t r_wmark;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_wmark <= '0;
    else if (wmark_clr)      r_wmark <= level;
    else if (level > r_wmark) r_wmark <= level;
  end

  assign wmark = r_wmark;
`endif
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Scoreboard bench for sram_fifo_ctrl with a behavioural 1rw1r SRAM macro model on clk0/clk1.
module tb_sram_fifo_ctrl;
  import sram_fifo_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH+1:0] level;
  logic                  sram_csb0;
  logic                  sram_web0;
  logic [NUM_WMASKS-1:0] sram_wmask0;
  logic [ADDR_WIDTH-1:0] sram_addr0;
  logic [DATA_WIDTH-1:0] sram_din0;
  logic                  sram_csb1;
  logic [ADDR_WIDTH-1:0] sram_addr1;
  logic [DATA_WIDTH-1:0] sram_dout1;
`ifdef SRAM_FIFO_WMARK_EN
  logic                  wmark_clr;
  logic [ADDR_WIDTH+1:0] wmark;
`endif

  int errors = 0;
  int checks = 0;
  int n_push = 0;
  int n_pop  = 0;
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic [DATA_WIDTH-1:0] mem[DEPTH];

  always #5 clk = ~clk;

  sram_fifo_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_csb1   (sram_csb1),
    .sram_addr1  (sram_addr1),
`ifdef SRAM_FIFO_WMARK_EN
    .wmark_clr   (wmark_clr),
    .wmark       (wmark),
`endif
    .sram_dout1  (sram_dout1)
  );

  // Macro model: byte-masked write on port 0, registered read on port 1
  always @(posedge clk) begin
    if (!sram_csb0 && !sram_web0)
      for (int b = 0; b < NUM_WMASKS; b++)
        if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int bound);
    int t = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (exp_q.size() != 0 && t < bound) begin
      cyc();
      t++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: everything the DUT does on the coming edge is judged at the preceding negedge
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      chk("level_vs_model", 64'(level), 64'(exp_q.size()));
      if (in_ready && exp_q.size() >= DEPTH + 2) chk("overflow_ready", 64'(in_ready), 64'd0);
      if (!sram_csb0 && !sram_csb1) chk("rw_same_addr", 64'(sram_addr0 == sram_addr1), 64'd0);
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) chk("pop_when_empty", 64'(out_valid), 64'd0);
        else chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        n_push++;
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int k, gaps, t, start;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef SRAM_FIFO_WMARK_EN
    wmark_clr = 1'b0;
`endif
    repeat (3) cyc();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_level",     64'(level),     64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_csb0",      64'(sram_csb0), 64'd1);
    chk("rst_csb1",      64'(sram_csb1), 64'd1);
    chk("rst_web0",      64'(sram_web0), 64'd1);
    chk("rst_wmask0",    64'(sram_wmask0), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // Single word: out_valid two cycles after the write edge, no bypass
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5_0001;
    cyc();
    in_valid = 1'b0;
    chk("t1_no_bypass", 64'(out_valid), 64'd0);
    k = 0;
    while (!out_valid && k < 10) begin cyc(); k++; end
    chk("t1_latency", 64'(k), 64'd2);
    cyc();
    chk("t1_level_zero", 64'(level), 64'd0);
    chk("t1_pop_count",  64'(n_pop), 64'd1);

    // Fill to full with the consumer stalled
    out_ready = 1'b0; start = n_push;
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      cyc();
    end
    in_valid = 1'b0;
    chk("t2_accepted",  64'(n_push - start), 64'd514);
    chk("t2_level_max", 64'(level),          64'd514);
    chk("t2_full_rdy",  64'(in_ready),       64'd0);
    out_ready = 1'b1; gaps = 0; t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      cyc(); t++;
      if (exp_q.size() != 0 && !out_valid) gaps++;
    end
    chk("t2_drained", 64'(exp_q.size()), 64'd0);
    chk("t2_no_gaps", 64'(gaps), 64'd0);

    // Streaming across several pointer wraps
    start = n_pop;
    for (int i = 0; i < 2000; i++) begin
      in_valid = 1'b1; in_data = 32'h3000_0000 + 32'(i);
      cyc();
    end
    chk("t3_throughput", 64'((n_pop - start) >= 1995), 64'd1);
    drain("t3_drained", 100);

    // Random backpressure with a continuous producer
    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'b1; in_data = $urandom; out_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    drain("t4_drained", 2000);

    // Reset while a read is in flight
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1; in_data = 32'h5000_0000 + 32'(i);
      cyc();
    end
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    in_valid = 1'b0;
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_level",     64'(level),     64'd0);
    chk("t5_csb0",      64'(sram_csb0), 64'd1);
    chk("t5_csb1",      64'(sram_csb1), 64'd1);
    repeat (2) cyc();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) cyc();
    chk("t5_no_residual", 64'(out_valid), 64'd0);
    start = n_pop;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 32'h6000_0000 + 32'(i);
      cyc();
    end
    drain("t5_drained", 100);
    chk("t5_pop_count", 64'(n_pop - start), 64'd20);

`ifdef SRAM_FIFO_WMARK_EN
    out_ready = 1'b0; wmark_clr = 1'b1;
    cyc();
    wmark_clr = 1'b0;
    chk("t6_wmark_clr0", 64'(wmark), 64'd0);
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = 32'h7000_0000 + 32'(i);
      cyc();
    end
    in_valid = 1'b0;
    chk("t6_level100", 64'(level), 64'd100);
    drain("t6_drained", 300);
    chk("t6_wmark100", 64'(wmark), 64'd100);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h7100_0000 + 32'(i);
      cyc();
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("t6_level3", 64'(level), 64'd3);
    wmark_clr = 1'b1;
    cyc();
    wmark_clr = 1'b0;
    chk("t6_wmark3", 64'(wmark), 64'd3);
    drain("t6_final_drain", 50);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
